// File: rtl/matmul_pkg.sv
// Shared matrix-multiply accelerator parameters, result-matrix type and
// the C streamer state encoding.
package matmul_pkg;

    localparam int N          = 2;
    localparam int M          = 2;
    localparam int K          = 2;
    localparam int DATA_WIDTH = 8;
    localparam int C_WIDTH    = 2 * DATA_WIDTH + $clog2(K);

    typedef logic [N-1:0][M-1:0][C_WIDTH-1:0] matC;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} c_stream_state_t;

    // Index width for a dimension of n entries; a single-entry dimension still gets one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_rc_counter.sv
// Row-major row/col position counter with wrap-around and last-column /
// last-element decode; shared by the C streamer and the A/B loaders.
module matmul_rc_counter #(
    parameter int ROWS = matmul_pkg::N,
    parameter int COLS = matmul_pkg::M
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clear,
    input  logic                                  advance,
    output logic [matmul_pkg::cnt_width(ROWS)-1:0] row,
    output logic [matmul_pkg::cnt_width(COLS)-1:0] col,
    output logic                                  col_last,
    output logic                                  last
);
    localparam int RW = matmul_pkg::cnt_width(ROWS);
    localparam int CW = matmul_pkg::cnt_width(COLS);

    logic [RW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic          row_last;

    assign row      = row_reg;
    assign col      = col_reg;
    assign col_last = (col_reg == CW'(COLS - 1));
    assign row_last = (row_reg == RW'(ROWS - 1));
    assign last     = col_last && row_last;

    // Both counters wrap to zero after the final element so they never leave range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (clear) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (advance) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_last ? '0 : row_reg + RW'(1);
            end else begin
                col_reg <= col_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/matmul_c_streamer.sv
// Captures a finished C matrix on start and streams it row-major over valid/ready,
// ending with a one-cycle done pulse. Define MATMUL_STREAM_IDX_EN to add out_row_o/out_col_o.
module matmul_c_streamer #(
    parameter int N       = matmul_pkg::N,
    parameter int M       = matmul_pkg::M,
    parameter int C_WIDTH = matmul_pkg::C_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_i,
    input  logic [N-1:0][M-1:0][C_WIDTH-1:0]    mat_c_i,
    output logic                                busy_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [C_WIDTH-1:0]                  out_data_o,
    output logic                                row_last_o,
    output logic                                out_last_o,
`ifdef MATMUL_STREAM_IDX_EN
    output logic [matmul_pkg::cnt_width(N)-1:0] out_row_o,
    output logic [matmul_pkg::cnt_width(M)-1:0] out_col_o,
`endif
    output logic                                done_o
);
    import matmul_pkg::*;

    localparam int RW = cnt_width(N);
    localparam int CW = cnt_width(M);

    c_stream_state_t                    state_reg, state_next;
    logic [N-1:0][M-1:0][C_WIDTH-1:0]   buf_reg;
    logic [RW-1:0]                      row;
    logic [CW-1:0]                      col;
    logic                               col_last, last;
    logic                               streaming, start_accept, handshake;

    assign streaming    = (state_reg == ST_STREAM);
    assign start_accept = (state_reg == ST_IDLE) && start_i;
    assign handshake    = streaming && out_ready_i;

    matmul_rc_counter #(
        .ROWS (N),
        .COLS (M)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_accept),
        .advance  (handshake),
        .row      (row),
        .col      (col),
        .col_last (col_last),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            buf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                buf_reg <= mat_c_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start_i) state_next = ST_STREAM;
            ST_STREAM: if (handshake && last) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Element-side outputs are forced to zero outside STREAM so idle matches the reset view.
    assign busy_o      = (state_reg != ST_IDLE);
    assign done_o      = (state_reg == ST_DONE);
    assign out_valid_o = streaming;
    assign out_data_o  = streaming ? buf_reg[row][col] : '0;
    assign row_last_o  = streaming && col_last;
    assign out_last_o  = streaming && last;

`ifdef MATMUL_STREAM_IDX_EN
    assign out_row_o = streaming ? row : '0;
    assign out_col_o = streaming ? col : '0;
`endif

endmodule

// File: tb/tb_matmul_c_streamer.sv
// Directed self-checking bench for matmul_c_streamer (2x2 default build plus a 3x1 instance).
module tb_matmul_c_streamer;
    import matmul_pkg::*;

    localparam int W = C_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2x2 instance
    logic                    start, ready;
    logic [1:0][1:0][W-1:0]  mat;
    logic                    busy, valid, rl, ol, done;
    logic [W-1:0]            data;
`ifdef MATMUL_STREAM_IDX_EN
    logic [0:0]              orow, ocol;
`endif

    // 3x1 instance
    logic                    start3, ready3;
    logic [2:0][0:0][W-1:0]  mat3;
    logic                    busy3, valid3, rl3, ol3, done3;
    logic [W-1:0]            data3;
`ifdef MATMUL_STREAM_IDX_EN
    logic [1:0]              orow3;
    logic [0:0]              ocol3;
`endif

    int errors = 0;
    int checks = 0;

    matmul_c_streamer #(.N(2), .M(2), .C_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .mat_c_i     (mat),
        .busy_o      (busy),
        .out_valid_o (valid),
        .out_ready_i (ready),
        .out_data_o  (data),
        .row_last_o  (rl),
        .out_last_o  (ol),
`ifdef MATMUL_STREAM_IDX_EN
        .out_row_o   (orow),
        .out_col_o   (ocol),
`endif
        .done_o      (done)
    );

    matmul_c_streamer #(.N(3), .M(1), .C_WIDTH(W)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start3),
        .mat_c_i     (mat3),
        .busy_o      (busy3),
        .out_valid_o (valid3),
        .out_ready_i (ready3),
        .out_data_o  (data3),
        .row_last_o  (rl3),
        .out_last_o  (ol3),
`ifdef MATMUL_STREAM_IDX_EN
        .out_row_o   (orow3),
        .out_col_o   (ocol3),
`endif
        .done_o      (done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        mat[0][0] = W'(a);
        mat[0][1] = W'(b);
        mat[1][0] = W'(c);
        mat[1][1] = W'(d);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, valid, rl, ol, done} !== 5'b0 || data !== '0) begin
            errors++;
            $display("FAIL reset_2x2: busy=%b valid=%b row_last=%b out_last=%b done=%b data=%0d, want all 0",
                     busy, valid, rl, ol, done, data);
        end
        checks++;
        if ({busy3, valid3, rl3, ol3, done3} !== 5'b0 || data3 !== '0) begin
            errors++;
            $display("FAIL reset_3x1: busy=%b valid=%b row_last=%b out_last=%b done=%b data=%0d, want all 0",
                     busy3, valid3, rl3, ol3, done3, data3);
        end
`ifdef MATMUL_STREAM_IDX_EN
        checks++;
        if (orow !== 1'b0 || ocol !== 1'b0) begin
            errors++;
            $display("FAIL reset_idx: row=%0d col=%0d, want 0 0", orow, ocol);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_order();
        int exp_d[4]  = '{1, 2, 3, 4};
        bit exp_rl[4] = '{0, 1, 0, 1};
        bit exp_ol[4] = '{0, 0, 0, 1};
        load(1, 2, 3, 4);
        ready = 1'b1;
        start_pulse();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid !== 1'b1 || data !== W'(exp_d[i]) || rl !== exp_rl[i] || ol !== exp_ol[i] || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_elem%0d: valid=%b data=%0d row_last=%b out_last=%b done=%b, want 1 %0d %b %b 0",
                         i, valid, data, rl, ol, done, exp_d[i], exp_rl[i], exp_ol[i]);
            end
            $display("basic elem %0d: data=%0d row_last=%b out_last=%b", i, data, rl, ol);
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: done=%b valid=%b busy=%b, want 1 0 1", done, valid, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        int exp_after[3] = '{2, 3, 4};
        load(1, 2, 3, 4);
        ready = 1'b1;
        start_pulse();
        tick();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (valid !== 1'b1 || data !== W'(2) || rl !== 1'b1 || ol !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%0d row_last=%b out_last=%b, want 1 2 1 0",
                         k, valid, data, rl, ol);
            end
            tick();
        end
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid !== 1'b1 || data !== W'(exp_after[i])) begin
                errors++;
                $display("FAIL bp_seq%0d: valid=%b data=%0d, want 1 %0d", i, valid, data, exp_after[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int exp_rest[3] = '{2, 3, 4};
        load(1, 2, 3, 4);
        ready = 1'b1;
        start_pulse();
        load(9, 9, 9, 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid !== 1'b1 || data !== W'(exp_rest[i])) begin
                errors++;
                $display("FAIL ign_seq%0d: valid=%b data=%0d, want 1 %0d", i, valid, data, exp_rest[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ign_done: done=%b, want 1", done);
        end
        tick();
        start_pulse();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid !== 1'b1 || data !== W'(9)) begin
                errors++;
                $display("FAIL ign_nines%0d: valid=%b data=%0d, want 1 9", i, valid, data);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ign_nines_done: done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int exp_d[4] = '{5, 6, 7, 8};
        bit saw_done = 1'b0;
        load(1, 2, 3, 4);
        ready = 1'b1;
        start_pulse();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, rl, ol, done} !== 5'b0 || data !== '0) begin
            errors++;
            $display("FAIL mrst_async: busy=%b valid=%b row_last=%b out_last=%b done=%b data=%0d, want all 0",
                     busy, valid, rl, ol, done, data);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mrst_nodone: saw_done=%b busy=%b, want 0 0", saw_done, busy);
        end
        load(5, 6, 7, 8);
        start_pulse();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid !== 1'b1 || data !== W'(exp_d[i])) begin
                errors++;
                $display("FAIL mrst_fresh%0d: valid=%b data=%0d, want 1 %0d", i, valid, data, exp_d[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL mrst_done: done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_degenerate();
        int exp_d[3]  = '{5, 6, 7};
        bit exp_ol[3] = '{0, 0, 1};
        int cyc;
        int idx = 0;
        mat3[0][0] = W'(5);
        mat3[1][0] = W'(6);
        mat3[2][0] = W'(7);
        ready3 = 1'b1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 20) begin
            if (valid3 === 1'b1 && idx < 3) begin
                checks++;
                if (data3 !== W'(exp_d[idx]) || rl3 !== 1'b1 || ol3 !== exp_ol[idx]) begin
                    errors++;
                    $display("FAIL deg_elem%0d: data=%0d row_last=%b out_last=%b, want %0d 1 %b",
                             idx, data3, rl3, ol3, exp_d[idx], exp_ol[idx]);
                end
                $display("degenerate elem %0d: data=%0d row_last=%b out_last=%b", idx, data3, rl3, ol3);
                idx++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (done3 !== 1'b1 || cyc != 4 || idx != 3) begin
            errors++;
            $display("FAIL deg_latency: done=%b cycles=%0d elems=%0d, want 1 4 3", done3, cyc, idx);
        end
        tick();
    endtask

    task automatic test_idx();
`ifdef MATMUL_STREAM_IDX_EN
        bit exp_r[4] = '{0, 0, 1, 1};
        bit exp_c[4] = '{0, 1, 0, 1};
        load(1, 2, 3, 4);
        ready = 1'b1;
        start_pulse();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (orow !== exp_r[i] || ocol !== exp_c[i]) begin
                errors++;
                $display("FAIL idx%0d: row=%0d col=%0d, want %0d %0d", i, orow, ocol, exp_r[i], exp_c[i]);
            end
            tick();
        end
        tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        ready  = 1'b1;
        mat    = '0;
        start3 = 1'b0;
        ready3 = 1'b1;
        mat3   = '0;
        tick();
        tick();
        test_reset();
        test_basic_order();
        test_backpressure();
        test_start_ignored();
        test_mid_reset();
        test_degenerate();
        test_idx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matmul_c_streamer.md
# matmul_c_streamer

Output stage of the matrix-multiply accelerator. Captures a completed N×M result matrix C from the compute array on a start pulse and serializes it element-by-element, in row-major order, over a valid/ready bus. This is the bus sampled by the golden checker and coverage. It also generates the per-matrix completion pulse the checker uses to close a result file.

## Interface
- `N`, default `matmul_pkg::N`: rows of C.
- `M`, default `matmul_pkg::M`: columns of C.
- `C_WIDTH`, default `matmul_pkg::C_WIDTH`: bit width of one C element.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle pulse meaning `mat_c_i` holds a valid result.
- `mat_c_i` in `matC`: full result matrix. Sampled only on an accepted start.
- `busy_o` out 1: high from the accepted start until `done_o`, inclusive.
- `out_valid_o` out 1: element valid.
- `out_ready_i` in 1: consumer ready.
- `out_data_o` out `C_WIDTH`: current element C[row][col].
- `row_last_o` out 1: current element is col == M-1.
- `out_last_o` out 1: current element is row == N-1 and col == M-1.
- `done_o` out 1: one-cycle pulse after the final handshake.

## Operation
- FSM states: IDLE, STREAM, DONE.
- **IDLE**
  - `start_i` = 1: register `mat_c_i` into the internal buffer, clear `row` and `col`, go to STREAM.
  - `start_i` = 0: stay in IDLE.
- **STREAM**
  - `out_valid_o` = 1. `out_data_o` = buf[row][col].
  - Handshake = `out_valid_o` & `out_ready_i`.
  - On each handshake, increment `col`. At M-1, wrap `col` to 0 and increment `row`.
  - A handshake on the element with `out_last_o` = 1 moves to DONE.
- **DONE**: `done_o` = 1 for exactly one cycle, then unconditionally go to IDLE.
- `start_i` in STREAM or DONE is ignored. It is not queued, and the buffer is not overwritten.
- Counter widths are `$clog2(N)` and `$clog2(M)`, minimum 1 bit. Counters never exceed N-1 / M-1.
- N = 1 or M = 1 are legal. With M = 1, `row_last_o` is high for every element.

## Timing
- Reset values: state IDLE, `busy_o` 0, `out_valid_o` 0, `out_last_o` 0, `row_last_o` 0, `done_o` 0, `out_data_o` 0, counters 0, buffer 0.
- Latency:
  - `start_i` high in cycle t gives `out_valid_o` = 1 with C[0][0] in cycle t+1.
  - The final handshake in cycle u gives `done_o` in cycle u+1.
  - The earliest next accepted start is cycle u+2.
- Throughput: with `out_ready_i` held high, one element per cycle. A matrix takes N·M+1 cycles from start to `done_o`.
- Handshake rules:
  - Once asserted, `out_valid_o` stays high until a handshake completes.
  - While `out_valid_o` = 1 and `out_ready_i` = 0, `out_data_o`, `row_last_o` and `out_last_o` hold stable.
  - `out_valid_o` never depends combinationally on `out_ready_i`.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Mid-operation reset: asynchronous return to the reset values. A partial matrix is discarded and `done_o` is not issued.

## Configuration
- `MATMUL_STREAM_IDX_EN` defined: adds `out_row_o` (`$clog2(N)`) and `out_col_o` (`$clog2(M)`) outputs.
  - They carry the current element's row/col and follow the same stability rules as `out_data_o`.
  - Reset value is 0.
  - Coverage uses them for per-position bins.
- `MATMUL_STREAM_IDX_EN` undefined: these ports do not exist, and the behaviour is otherwise identical.

## Structure
- `matmul_pkg` holds `N`, `M`, `K`, `DATA_WIDTH`, `C_WIDTH` and the `matC` typedef (N×M array of `C_WIDTH` vectors). It also adds `typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} c_stream_state_t`.
- One natural sub-module is `matmul_rc_counter`: the row/col counter with wrap and last-flag decode, reusable by an input-side A/B loader.

## Test plan
- **Basic order:** N=M=2, C=[[1,2],[3,4]], `out_ready_i` held 1.
  - Data 1,2,3,4 appears on consecutive cycles.
  - `row_last_o` is high on 2 and 4; `out_last_o` is high on 4 only.
  - `done_o` is high the cycle after the handshake on 4.
- **Backpressure:** `out_ready_i` low for 3 cycles while element 2 is presented.
  - Data stays 2 with `out_valid_o` high for all 3 cycles.
  - No element is skipped or repeated.
- **Start ignored:** pulse `start_i` with C=[[9,9],[9,9]] mid-stream.
  - The output still completes 1,2,3,4.
  - A new start after `done_o` streams the 9s.
- **Mid-operation reset:** assert `rst` after element 2's handshake.
  - All outputs are 0 immediately (asynchronous).
  - No `done_o` pulse occurs.
  - A fresh start streams from C[0][0].
- **Degenerate shape:** N=3, M=1, C=[5,6,7].
  - `row_last_o` is high on every element; `out_last_o` is high on 7 only.
  - The matrix takes 4 cycles from start to `done_o`.
- **`MATMUL_STREAM_IDX_EN` build:** `out_row_o`/`out_col_o` sequence is (0,0),(0,1),(1,0),(1,1) for N=M=2.
